clk_div_int: RTL and testbench

Parametrised integer clock divider, the successor to the basic counter divider. It produces `clk_out` at exactly f(clk_ref)/N with 50 % duty for both even and odd N; odd ratios use a negedge-extended high phase. Ratio changes are applied only at period boundaries, and ratios 0/1 give a glitch-free bypass. `clk_en` gating never truncates a pulse. It sits between the reference clock source and downstream peripherals needing programmable slow clocks.

---
 rtl/clk_div_int.sv | 49 ++++
 tb/tb_clk_div_int.sv | 118 +++++++++++
 2 files changed

// File: rtl/clk_div_int.sv
// clk_div_int: programmable integer clock divider with 50% duty, period-aligned ratio switching and glitch-free bypass
module clk_div_int #(
  parameter int WIDTH = 8
) (
  input  logic             clk_ref,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] div_ratio,
  output logic             clk_out,
  output logic             ratio_upd
);
  typedef enum logic [1:0] {IDLE, RUN, BYPASS} state_t;
  state_t st, st_nx, st_sel;
  logic [WIDTH-1:0] cnt, cnt_nx, n_act;
  logic p, p_nx, q, byp_en, big, last, load, go;
  always_comb begin
    big = div_ratio > WIDTH'(1);
    last = (st == RUN) && (cnt == n_act - WIDTH'(1));
    load = (st == IDLE && clk_en) || last || (st == BYPASS);
    go = (st == IDLE && clk_en) || last || (st == BYPASS && !byp_en);
    st_sel = !clk_en ? IDLE : big ? RUN : BYPASS;
    st_nx = go ? st_sel : st;
    cnt_nx = go ? '0 : (st == RUN) ? cnt + WIDTH'(1) : cnt;
    p_nx = go ? (clk_en && big) : (st == RUN) ? (cnt_nx < (n_act >> 1)) : p;
  end
  always_ff @(posedge clk_ref or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      cnt <= '0;
      n_act <= '0;
      p <= 1'b0;
      ratio_upd <= 1'b0;
    end else begin
      st <= st_nx;
      cnt <= cnt_nx;
      n_act <= load ? div_ratio : n_act;
      p <= p_nx;
      ratio_upd <= load && (div_ratio != n_act);
    end
  always_ff @(negedge clk_ref or negedge rst_n)
    if (!rst_n) begin
      q <= 1'b0;
      byp_en <= 1'b0;
    end else begin
      q <= p;
      byp_en <= (st == BYPASS) && clk_en && (n_act <= WIDTH'(1));
    end
  assign clk_out = p | (n_act[0] & q) | (clk_ref & byp_en);
endmodule

// File: tb/tb_clk_div_int.sv
// tb_clk_div_int: directed table-driven and sequence checks of clk_div_int waveforms
module tb_clk_div_int;
  logic clk_ref = 1'b0;
  logic rst_n = 1'b0;
  logic clk_en = 1'b0;
  logic [7:0] div_ratio = 8'd0;
  logic clk_out, ratio_upd;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [7:0] ratio;
    int halves;
    int per_h;
    int hi_h;
    bit byp;
    int upd_cyc;
  } vec_t;
  vec_t vecs[9];
  clk_div_int #(.WIDTH(8)) dut (
    .clk_ref(clk_ref),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .div_ratio(div_ratio),
    .clk_out(clk_out),
    .ratio_upd(ratio_upd)
  );
  always #5 clk_ref = ~clk_ref;
  task automatic chk(input string name, input int h, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s h=%0d got %b want %b", name, h, act, exp);
    end
  endtask
  task automatic check_wave(input string tag, input int per_h, input int hi_h, input bit byp,
                            input int h0, input int h1, input int upd_cyc);
    for (int h = h0; h < h1; h++) begin
      if (h % 2 == 0) @(posedge clk_ref);
      else @(negedge clk_ref);
      #1;
      chk({tag, " clk_out"}, h, clk_out, byp ? (h >= 2 && h % 2 == 0) : ((h % per_h) < hi_h));
      chk({tag, " ratio_upd"}, h, ratio_upd, (h / 2) == upd_cyc);
    end
  endtask
  task automatic check_low(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) @(posedge clk_ref);
      else @(negedge clk_ref);
      #1;
      chk(tag, i, clk_out, 1'b0);
    end
  endtask
  task automatic do_reset();
    @(negedge clk_ref);
    clk_en = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("reset clk_out", 0, clk_out, 1'b0);
    chk("reset ratio_upd", 0, ratio_upd, 1'b0);
    rst_n = 1'b1;
  endtask
  task automatic enable(input logic [7:0] r);
    @(negedge clk_ref);
    div_ratio = r;
    clk_en = 1'b1;
  endtask
  initial begin
    vecs[0] = '{8'd2, 24, 4, 2, 1'b0, 0};
    vecs[1] = '{8'd3, 24, 6, 3, 1'b0, 0};
    vecs[2] = '{8'd4, 24, 8, 4, 1'b0, 0};
    vecs[3] = '{8'd5, 30, 10, 5, 1'b0, 0};
    vecs[4] = '{8'd7, 28, 14, 7, 1'b0, 0};
    vecs[5] = '{8'd8, 32, 16, 8, 1'b0, 0};
    vecs[6] = '{8'd255, 1020, 510, 255, 1'b0, 0};
    vecs[7] = '{8'd1, 12, 1, 1, 1'b1, 0};
    vecs[8] = '{8'd0, 12, 1, 1, 1'b1, -1};
    foreach (vecs[i]) begin
      do_reset();
      enable(vecs[i].ratio);
      check_wave($sformatf("vec%0d", i), vecs[i].per_h, vecs[i].hi_h, vecs[i].byp, 0, vecs[i].halves, vecs[i].upd_cyc);
    end
    do_reset();
    enable(8'd4);
    check_wave("chg4", 8, 4, 1'b0, 0, 3, 0);
    div_ratio = 8'd6;
    check_wave("chg4", 8, 4, 1'b0, 3, 8, -1);
    check_wave("chg6", 12, 6, 1'b0, 0, 24, 0);
    do_reset();
    enable(8'd8);
    check_wave("dis", 16, 8, 1'b0, 0, 3, 0);
    clk_en = 1'b0;
    check_wave("dis", 16, 8, 1'b0, 3, 16, -1);
    check_low("dis idle", 10);
    clk_en = 1'b1;
    check_wave("reen", 16, 8, 1'b0, 0, 16, -1);
    do_reset();
    enable(8'd1);
    check_wave("byp", 1, 1, 1'b1, 0, 12, 0);
    div_ratio = 8'd3;
    check_wave("byp exit", 1, 1, 1'b1, 12, 14, 6);
    check_wave("div3", 6, 3, 1'b0, 0, 18, -1);
    do_reset();
    enable(8'd7);
    check_wave("rst", 14, 7, 1'b0, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    clk_en = 1'b0;
    #1;
    chk("midreset clk_out", 0, clk_out, 1'b0);
    chk("midreset ratio_upd", 0, ratio_upd, 1'b0);
    rst_n = 1'b1;
    check_low("rst idle", 10);
    clk_en = 1'b1;
    check_wave("rst re", 14, 7, 1'b0, 0, 14, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
